// File: rtl/pkt_tx_sched.sv
// pkt_tx_sched: round-robin, packet-granular scheduler from per-VC TX flit queues
// into the packet processor request interface; one registered output flit.
module pkt_tx_sched #(
   parameter int NUM_VC    = 2,
   parameter int VC_WIDTH  = 1,
   parameter int FLIT_DATA = 32,
   parameter int PKT_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          arst,
   input  logic [NUM_VC-1:0]             vc_valid,
   input  logic [NUM_VC*FLIT_DATA-1:0]   vc_data,
   input  logic [NUM_VC*PKT_WIDTH-1:0]   vc_pkt_sz,
   output logic [NUM_VC-1:0]             vc_ready,
   output logic                          out_valid,
   output logic                          out_req_new,
   output logic                          out_req_last,
   output logic [FLIT_DATA-1:0]          out_flit_data,
   output logic [PKT_WIDTH-1:0]          out_pkt_sz,
   output logic [VC_WIDTH-1:0]           out_vc_id,
   input  logic                          out_ready,
   output logic                          busy
);
   typedef enum logic {IDLE, BURST} state_t;
   state_t               state_q, state_d;
   logic [VC_WIDTH-1:0]  rr_q, rr_d, grant_q, grant_d, vcid_q, vcid_d, win, src;
   logic [PKT_WIDTH-1:0] rem_q, rem_d, sz_q, sz_d, src_sz;
   logic [FLIT_DATA-1:0] data_q, data_d, src_data;
   logic                 valid_q, valid_d, new_q, new_d, last_q, last_d;
   logic                 load, src_ok, take, head, last_flit;

   function automatic logic [VC_WIDTH-1:0] inc(input logic [VC_WIDTH-1:0] v);
      return (v == VC_WIDTH'(NUM_VC - 1)) ? '0 : v + VC_WIDTH'(1);
   endfunction

   // first requester at or after ptr, with wrap; scanned backwards so the nearest wins
   function automatic logic [VC_WIDTH-1:0] pick(input logic [NUM_VC-1:0] req,
                                                input logic [VC_WIDTH-1:0] ptr);
      logic [VC_WIDTH:0] s;
      pick = ptr;
      for (int i = NUM_VC - 1; i >= 0; i--) begin
         s = {1'b0, ptr} + (VC_WIDTH+1)'(i);
         if (s >= (VC_WIDTH+1)'(NUM_VC)) s = s - (VC_WIDTH+1)'(NUM_VC);
         if (req[s[VC_WIDTH-1:0]]) pick = s[VC_WIDTH-1:0];
      end
   endfunction

   assign load      = !valid_q || out_ready;
   assign win       = pick(vc_valid, rr_q);
   assign head      = state_q == IDLE;
   assign src       = head ? win : grant_q;
   assign src_ok    = head ? |vc_valid : vc_valid[grant_q];
   assign take      = load && src_ok;
   assign src_sz    = vc_pkt_sz[int'(src)*PKT_WIDTH +: PKT_WIDTH];
   assign src_data  = vc_data[int'(src)*FLIT_DATA +: FLIT_DATA];
   assign last_flit = !head && rem_q == PKT_WIDTH'(1);

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
         new_q   <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         sz_q    <= '0;
         vcid_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
         new_q   <= new_d;
         last_q  <= last_d;
         data_q  <= data_d;
         sz_q    <= sz_d;
         vcid_q  <= vcid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      rem_d   = rem_q;
      if (take && head) begin
         if (src_sz == '0) rr_d = inc(src);
         else begin
            state_d = BURST;
            grant_d = src;
            rem_d   = src_sz;
         end
      end else if (take) begin
         rem_d = rem_q - PKT_WIDTH'(1);
         if (last_flit) begin
            state_d = IDLE;
            rr_d    = inc(grant_q);
         end
      end
   end

   // the output register only moves on load; a stalled flit holds every field
   always_comb begin
      valid_d  = load ? take : valid_q;
      new_d    = load ? take && head : new_q;
      last_d   = load ? take && last_flit : last_q;
      data_d   = load ? (take ? src_data : '0) : data_q;
      sz_d     = load ? (take && head ? src_sz : '0) : sz_q;
      vcid_d   = load ? (take ? src : '0) : vcid_q;
      vc_ready = take ? NUM_VC'(1) << src : '0;
   end

   assign out_valid     = valid_q;
   assign out_req_new   = new_q;
   assign out_req_last  = last_q;
   assign out_flit_data = data_q;
   assign out_pkt_sz    = sz_q;
   assign out_vc_id     = vcid_q;
   assign busy          = state_q == BURST;
endmodule

// File: tb/tb_pkt_tx_sched.sv
// tb_pkt_tx_sched: vector table, hand-written corner sequences and a randomized run
// against a queue-based packet model for pkt_tx_sched.
module tb_pkt_tx_sched;
   localparam int NV = 2, FD = 32, PW = 8;
   logic            clk = 1'b0, arst = 1'b0, out_ready = 1'b0;
   logic [NV-1:0]   vc_valid = '0, vc_ready;
   logic [NV*FD-1:0] vc_data = '0;
   logic [NV*PW-1:0] vc_pkt_sz = '0;
   logic            out_valid, out_req_new, out_req_last, busy, out_vc_id;
   logic [FD-1:0]   out_flit_data;
   logic [PW-1:0]   out_pkt_sz;
   int              checks = 0, errors = 0;

   always #5 clk = ~clk;

   pkt_tx_sched #(.NUM_VC(NV), .VC_WIDTH(1), .FLIT_DATA(FD), .PKT_WIDTH(PW)) dut (
      .clk(clk), .arst(arst), .vc_valid(vc_valid), .vc_data(vc_data), .vc_pkt_sz(vc_pkt_sz),
      .vc_ready(vc_ready), .out_valid(out_valid), .out_req_new(out_req_new),
      .out_req_last(out_req_last), .out_flit_data(out_flit_data), .out_pkt_sz(out_pkt_sz),
      .out_vc_id(out_vc_id), .out_ready(out_ready), .busy(busy));

   typedef struct {
      logic [1:0] vv; logic [31:0] d0, d1; logic [7:0] s0, s1; logic rdy;
      logic [1:0] e_vr; logic e_ov, e_nw, e_ls; logic [31:0] e_d; logic [7:0] e_sz; logic e_vc, e_bz;
   } vec_t;
   typedef struct packed { logic [31:0] d; logic [7:0] sz; logic hd; logic tl; } flit_t;
   typedef struct packed { logic [31:0] d; logic nw; logic ls; logic [7:0] sz; logic vc; } exp_t;

   vec_t  tbl[$];
   flit_t vq[NV][$];
   exp_t  expq[$];
   int    m_rr, m_grant, m_rem;
   bit    m_burst;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, {vc_ready, out_valid, out_req_new, out_req_last, out_flit_data, out_pkt_sz,
               out_vc_id, busy}, 64'd0);
   endtask

   task automatic chk_out(input string nm, input logic ov, nw, ls, input logic [31:0] d,
                          input logic [7:0] sz, input logic vc, bz);
      chk({nm, "_ov_busy"}, {out_valid, busy}, {ov, bz});
      if (ov) chk({nm, "_flit"}, {out_req_new, out_req_last, out_flit_data, out_pkt_sz, out_vc_id},
                  {nw, ls, d, sz, vc});
   endtask

   task automatic step(input logic [1:0] vv, input logic [31:0] d0, d1,
                       input logic [7:0] s0, s1, input logic rdy);
      @(negedge clk);
      vc_valid  = vv;
      vc_data   = {d1, d0};
      vc_pkt_sz = {s1, s0};
      out_ready = rdy;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst = 1'b0; vc_valid = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      arst = 1'b1;
      for (int v = 0; v < NV; v++) vq[v].delete();
      expq.delete();
      m_rr = 0; m_grant = 0; m_rem = 0; m_burst = 1'b0;
   endtask

   task automatic gen_pkt(input int v, input int fixed);
      int n;
      flit_t f;
      n = (fixed >= 0) ? fixed : int'($urandom_range(0, 4));
      for (int k = 0; k <= n; k++) begin
         f.d  = $urandom;
         f.hd = k == 0;
         f.sz = (k == 0) ? 8'(n) : 8'($urandom);
         f.tl = k == n && n > 0;
         vq[v].push_back(f);
      end
   endtask

   // model: per-VC packet queues, expected output flit, round-robin pointer and open packet
   task automatic run_model(input int cycles, input int vpct, input int rpct, input int fixed);
      bit ld;
      int ev;
      logic [1:0] evr;
      flit_t f;
      exp_t e;
      for (int c = 0; c < cycles; c++) begin
         for (int v = 0; v < NV; v++) if (vq[v].size() < 2) gen_pkt(v, fixed);
         @(negedge clk);
         for (int v = 0; v < NV; v++) begin
            vc_valid[v] = int'($urandom_range(0, 99)) < vpct;
            vc_data[v*FD +: FD] = vq[v][0].d;
            vc_pkt_sz[v*PW +: PW] = vq[v][0].sz;
         end
         out_ready = int'($urandom_range(0, 99)) < rpct;
         #1;
         chk("rnd_ov", out_valid, expq.size() != 0);
         chk("rnd_busy", busy, m_burst);
         ld = expq.size() == 0 || out_ready;
         if (expq.size() != 0) begin
            e = expq[0];
            chk("rnd_flit", {out_flit_data, out_req_new, out_req_last, out_pkt_sz, out_vc_id}, e);
            if (out_ready) void'(expq.pop_front());
         end
         ev = -1;
         if (ld && m_burst) ev = vc_valid[m_grant] ? m_grant : -1;
         else if (ld)
            for (int i = 0; i < NV; i++) if (ev < 0 && vc_valid[(m_rr + i) % NV]) ev = (m_rr + i) % NV;
         evr = (ev < 0) ? 2'b00 : 2'b01 << ev;
         chk("rnd_pop", vc_ready, evr);
         if (ev >= 0) begin
            f = vq[ev].pop_front();
            expq.push_back('{f.d, f.hd, f.tl, f.hd ? f.sz : 8'd0, ev[0]});
            if (f.hd && f.sz != 0) begin
               m_burst = 1'b1; m_grant = ev; m_rem = int'(f.sz);
            end else if (f.hd) m_rr = (ev + 1) % NV;
            else begin
               m_rem--;
               if (m_rem == 0) begin m_burst = 1'b0; m_rr = (m_grant + 1) % NV; end
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
      $fatal(1);
   end

   initial begin
      // reset held, then released with no requests
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (i == 5) arst = 1'b1;
         #1;
         chk_zero($sformatf("idle_reset%0d", i));
      end

      // single flit on VC1, 4-flit packet on VC0 under stalls, round-robin pick from rr=1
      tbl.push_back('{2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0, 1'b0});
      tbl.push_back('{2'b10, 32'h0, 32'hA5A5_0001, 8'd0, 8'd0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0, 1'b0});
      tbl.push_back('{2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 32'hA5A5_0001, 8'd0, 1'b1, 1'b0});
      tbl.push_back('{2'b01, 32'hD000_0000, 32'h0, 8'd3, 8'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0, 1'b0});
      tbl.push_back('{2'b01, 32'hD000_0001, 32'h0, 8'd7, 8'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 32'hD000_0000, 8'd3, 1'b0, 1'b1});
      tbl.push_back('{2'b01, 32'hD000_0001, 32'h0, 8'd7, 8'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 32'hD000_0000, 8'd3, 1'b0, 1'b1});
      tbl.push_back('{2'b01, 32'hD000_0001, 32'h0, 8'd7, 8'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'hD000_0000, 8'd3, 1'b0, 1'b1});
      tbl.push_back('{2'b01, 32'hD000_0002, 32'h0, 8'd7, 8'd0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'hD000_0001, 8'd0, 1'b0, 1'b1});
      tbl.push_back('{2'b01, 32'hD000_0003, 32'h0, 8'd7, 8'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'hD000_0002, 8'd0, 1'b0, 1'b1});
      tbl.push_back('{2'b01, 32'hD000_0003, 32'h0, 8'd7, 8'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'hD000_0002, 8'd0, 1'b0, 1'b1});
      tbl.push_back('{2'b01, 32'hD000_0003, 32'h0, 8'd7, 8'd0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'hD000_0002, 8'd0, 1'b0, 1'b1});
      tbl.push_back('{2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 32'hD000_0003, 8'd0, 1'b0, 1'b0});
      tbl.push_back('{2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 32'hD000_0003, 8'd0, 1'b0, 1'b0});
      tbl.push_back('{2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0, 1'b0});
      tbl.push_back('{2'b11, 32'hE000_0000, 32'hE000_0001, 8'd0, 8'd0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0, 1'b0});
      tbl.push_back('{2'b11, 32'hE000_0000, 32'hE000_0001, 8'd0, 8'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'hE000_0001, 8'd0, 1'b1, 1'b0});
      tbl.push_back('{2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 32'hE000_0000, 8'd0, 1'b0, 1'b0});
      foreach (tbl[i]) begin
         step(tbl[i].vv, tbl[i].d0, tbl[i].d1, tbl[i].s0, tbl[i].s1, tbl[i].rdy);
         chk($sformatf("tbl%0d_vr", i), vc_ready, tbl[i].e_vr);
         chk_out($sformatf("tbl%0d", i), tbl[i].e_ov, tbl[i].e_nw, tbl[i].e_ls, tbl[i].e_d,
                 tbl[i].e_sz, tbl[i].e_vc, tbl[i].e_bz);
      end

      // bubble inside a VC0 burst while VC1 keeps requesting
      do_reset();
      step(2'b01, 32'hB0, 32'hF1, 8'd2, 8'd0, 1'b1); chk("bub_head_vr", vc_ready, 2'b01);
      step(2'b10, 32'h0, 32'hF1, 8'd0, 8'd0, 1'b1); chk("bub0_vr", vc_ready, 2'b00);
      chk_out("bub_head", 1, 1, 0, 32'hB0, 8'd2, 0, 1);
      for (int i = 1; i < 3; i++) begin
         step(2'b10, 32'h0, 32'hF1, 8'd0, 8'd0, 1'b1);
         chk($sformatf("bub%0d_vr", i), vc_ready, 2'b00);
         chk_out($sformatf("bub%0d", i), 0, 0, 0, 32'h0, 8'd0, 0, 1);
      end
      step(2'b11, 32'hB1, 32'hF1, 8'd9, 8'd0, 1'b1); chk("bub_res_vr", vc_ready, 2'b01);
      chk_out("bub3", 0, 0, 0, 32'h0, 8'd0, 0, 1);
      step(2'b11, 32'hB2, 32'hF1, 8'd9, 8'd0, 1'b1); chk("bub_tail_vr", vc_ready, 2'b01);
      chk_out("bub_body", 1, 0, 0, 32'hB1, 8'd0, 0, 1);
      step(2'b11, 32'hB2, 32'hF1, 8'd9, 8'd0, 1'b1); chk("bub_next_vr", vc_ready, 2'b10);
      chk_out("bub_tail", 1, 0, 1, 32'hB2, 8'd0, 0, 0);
      step(2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 1'b1);
      chk_out("bub_vc1", 1, 1, 0, 32'hF1, 8'd0, 1, 0);

      // asynchronous reset in the middle of a pkt_sz=5 packet
      do_reset();
      step(2'b01, 32'h50, 32'h0, 8'd0, 8'd0, 1'b1); chk("mrst_s_vr", vc_ready, 2'b01);
      step(2'b10, 32'h0, 32'h51, 8'd0, 8'd5, 1'b1); chk("mrst_h_vr", vc_ready, 2'b10);
      step(2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 1'b0);
      chk_out("mrst_head", 1, 1, 0, 32'h51, 8'd5, 1, 1);
      arst = 1'b0; #1;
      chk_zero("mrst_async");
      @(negedge clk); #1;
      chk_zero("mrst_held");
      arst = 1'b1;
      step(2'b11, 32'hC0, 32'hC1, 8'd0, 8'd0, 1'b1); chk("mrst_rr_vr", vc_ready, 2'b01);
      chk_out("mrst_idle", 0, 0, 0, 32'h0, 8'd0, 0, 0);
      step(2'b10, 32'h0, 32'hC1, 8'd0, 8'd0, 1'b1); chk("mrst_vc1_vr", vc_ready, 2'b10);
      chk_out("mrst_c0", 1, 1, 0, 32'hC0, 8'd0, 0, 0);
      step(2'b00, 32'h0, 32'h0, 8'd0, 8'd0, 1'b1);
      chk_out("mrst_c1", 1, 1, 0, 32'hC1, 8'd0, 1, 0);

      // both VCs saturated with 3-flit packets, then random traffic and stalls
      do_reset();
      run_model(60, 100, 100, 2);
      do_reset();
      run_model(1500, 75, 65, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
